// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: data_sram response wait, load extraction, flush drain
module mem_stage #(
    parameter int BUS_IN_WD  = 148,
    parameter int BUS_OUT_WD = 137
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  ws_allowin,
    output logic                  ms_allowin,
    input  logic                  es_to_ms_valid,
    input  logic [BUS_IN_WD-1:0]  es_to_ms_bus,
    input  logic                  es_mem_req_ok,
    output logic                  ms_to_ws_valid,
    output logic [BUS_OUT_WD-1:0] ms_to_ws_bus,
    output logic [9:0]            stall_ms_bus,
    output logic [32:0]           forward_ms_bus,
    output logic                  ms_exc_eret,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata
);

    logic                 ms_valid_q, ms_valid_d;
    logic                 mem_wait_q, mem_wait_d;
    logic                 rdata_buf_valid_q, rdata_buf_valid_d;
    logic [31:0]          rdata_buf_q, rdata_buf_d;
    logic [1:0]           discard_cnt_q, discard_cnt_d;
    logic [BUS_IN_WD-1:0] bus_q, bus_d;

    logic        tlb_flush, tlbr, tlbwi, tlbp;
    logic [31:0] index_wdata;
    logic        store_op, bd, exc;
    logic [14:0] exc_type;
    logic        eret, cp0_wen, res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic [6:0]  inst_load;
    logic [4:0]  ld_extd_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;

    assign {tlb_flush, tlbr, tlbwi, tlbp, index_wdata, store_op, bd, exc, exc_type,
            eret, cp0_wen, res_from_cp0, cp0_addr, res_from_mem, inst_load,
            ld_extd_op, gr_we, dest, alu_result, pc} = bus_q;

    logic inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw, inst_lwl, inst_lwr;
    assign {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw, inst_lwl, inst_lwr} = inst_load;

    // Load width is fully encoded by inst_load; these fields only matter upstream.
    logic unused_fields;
    assign unused_fields = ^{ld_extd_op, store_op};

    logic resp_hit, resp_take, ms_ready_go, ms_leave;
    logic [31:0] rdata_sel;

    assign resp_hit       = data_sram_data_ok && (discard_cnt_q == 2'd0);
    assign resp_take      = resp_hit && mem_wait_q && ms_valid_q;
    assign ms_ready_go    = !mem_wait_q || resp_hit;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;
    assign rdata_sel      = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

    logic [1:0]  addr_lo;
    logic [31:0] rdata_shr, rdata_shl;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] final_result;
    logic [3:0]  rf_we;

    assign addr_lo   = alu_result[1:0];
    assign rdata_shr = rdata_sel >> {addr_lo, 3'b000};
    // 3 - a equals ~a for a 2-bit offset.
    assign rdata_shl = rdata_sel << {~addr_lo, 3'b000};
    assign ld_byte   = rdata_shr[7:0];
    assign ld_half   = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

    always_comb begin
        ld_result = rdata_sel;
        if (inst_lb) begin
            ld_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (inst_lbu) begin
            ld_result = {24'd0, ld_byte};
        end else if (inst_lh) begin
            ld_result = {{16{ld_half[15]}}, ld_half};
        end else if (inst_lhu) begin
            ld_result = {16'd0, ld_half};
        end else if (inst_lwl) begin
            ld_result = rdata_shl;
        end else if (inst_lwr) begin
            ld_result = rdata_shr;
        end else if (inst_lw) begin
            ld_result = rdata_sel;
        end
    end

    always_comb begin
        rf_we = {4{gr_we}};
        if (inst_lwl) begin
            rf_we = (4'b1111 << (~addr_lo)) & {4{gr_we}};
        end else if (inst_lwr) begin
            rf_we = (4'b1111 >> addr_lo) & {4{gr_we}};
        end
        if (exc) begin
            rf_we = 4'b0000;
        end
    end

    assign final_result = res_from_mem ? ld_result : alu_result;

    assign ms_to_ws_bus = {tlb_flush, tlbr, tlbwi, tlbp, index_wdata, bd, exc, exc_type,
                           eret, cp0_wen, res_from_cp0, cp0_addr, rf_we, dest,
                           final_result, pc};

    assign stall_ms_bus   = {{5{ms_valid_q && gr_we}}, dest};
    // Partial-word loads merge in write-back, so they are never forwarded.
    assign forward_ms_bus = {ms_valid_q && gr_we && !res_from_cp0 && ms_ready_go
                             && !(inst_lwl || inst_lwr), final_result};
    assign ms_exc_eret    = ms_valid_q && (exc || eret || tlb_flush);

    logic       inc_wait, inc_new, dec_drop;
    logic [2:0] discard_sum;

    assign inc_wait    = flush && mem_wait_q && ms_valid_q && !resp_hit;
    assign inc_new     = flush && es_mem_req_ok && es_to_ms_valid;
    assign dec_drop    = data_sram_data_ok && (discard_cnt_q != 2'd0);
    assign discard_sum = {1'b0, discard_cnt_q} + {2'b00, inc_wait} + {2'b00, inc_new}
                       - {2'b00, dec_drop};

    always_comb begin
        ms_valid_d        = ms_valid_q;
        mem_wait_d        = mem_wait_q;
        rdata_buf_valid_d = rdata_buf_valid_q;
        rdata_buf_d       = rdata_buf_q;
        bus_d             = bus_q;
        discard_cnt_d     = (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
        if (flush) begin
            ms_valid_d        = 1'b0;
            mem_wait_d        = 1'b0;
            rdata_buf_valid_d = 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_d = es_to_ms_valid;
            end
            // A response in the handoff cycle belongs to the outgoing occupant.
            if (es_to_ms_valid && ms_allowin) begin
                bus_d      = es_to_ms_bus;
                mem_wait_d = es_mem_req_ok;
            end else if (resp_take) begin
                mem_wait_d = 1'b0;
            end
            if (ms_leave) begin
                rdata_buf_valid_d = 1'b0;
            end else if (resp_take) begin
                rdata_buf_valid_d = 1'b1;
                rdata_buf_d       = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q        <= 1'b0;
            mem_wait_q        <= 1'b0;
            rdata_buf_valid_q <= 1'b0;
            discard_cnt_q     <= 2'd0;
        end else begin
            ms_valid_q        <= ms_valid_d;
            mem_wait_q        <= mem_wait_d;
            rdata_buf_valid_q <= rdata_buf_valid_d;
            discard_cnt_q     <= discard_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q       <= bus_d;
        rdata_buf_q <= rdata_buf_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

    localparam logic [6:0] LB  = 7'b1000000;
    localparam logic [6:0] LBU = 7'b0100000;
    localparam logic [6:0] LH  = 7'b0010000;
    localparam logic [6:0] LHU = 7'b0001000;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;

    logic         clk = 1'b0;
    logic         reset, flush, ws_allowin, es_to_ms_valid, es_mem_req_ok;
    logic [147:0] es_to_ms_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_allowin, ms_to_ws_valid, ms_exc_eret;
    logic [136:0] ms_to_ws_bus;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;

    wire [31:0] out_res = ms_to_ws_bus[63:32];
    wire [3:0]  out_we  = ms_to_ws_bus[72:69];
    wire [31:0] out_pc  = ms_to_ws_bus[31:0];

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  we;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_mem_req_ok     (es_mem_req_ok),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus),
        .ms_exc_eret       (ms_exc_eret),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    function automatic logic [147:0] mk_in(input logic [6:0] ld, input logic gwe,
                                           input logic [4:0] dst, input logic [31:0] alu,
                                           input logic [31:0] pc, input logic exc,
                                           input logic [14:0] et, input logic st,
                                           input logic bd, input logic [31:0] idx);
        return {4'b0000, idx, st, bd, exc, et, 3'b000, 8'h00, |ld, ld, 5'b00000,
                gwe, dst, alu, pc};
    endfunction

    function automatic logic [136:0] mk_out(input logic [3:0] we, input logic [4:0] dst,
                                            input logic [31:0] res, input logic [31:0] pc,
                                            input logic exc, input logic [14:0] et,
                                            input logic bd, input logic [31:0] idx);
        return {4'b0000, idx, bd, exc, et, 3'b000, 8'h00, we, dst, res, pc};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL reset_handshake: got valid=%b allowin=%b want valid=0 allowin=1",
                     ms_to_ws_valid, ms_allowin);
        end
        total++;
        if (stall_ms_bus[9:5] !== 5'd0 || forward_ms_bus[32] !== 1'b0 || ms_exc_eret !== 1'b0) begin
            bad++;
            $display("FAIL reset_side: got mask=%h fwd=%b exc=%b want 0 0 0",
                     stall_ms_bus[9:5], forward_ms_bus[32], ms_exc_eret);
        end
    endtask

    task automatic test_lw();
        exp_t e;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd4, 32'h80001004, 32'hBFC00100, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        sb.push_back('{32'hDEADBEEF, 4'hF, 32'hBFC00100});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            es_mem_req_ok  = 1'b0;
            if (c == 3) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = 32'hDEADBEEF;
            end
            #1;
            if (c < 3) begin
                total++;
                if (ms_to_ws_valid !== 1'b0 || forward_ms_bus[32] !== 1'b0 ||
                    stall_ms_bus !== {5'h1f, 5'd4}) begin
                    bad++;
                    $display("FAIL lw_wait: cycle %0d got valid=%b fwd=%b stall=%h want 0 0 3e4",
                             c, ms_to_ws_valid, forward_ms_bus[32], stall_ms_bus);
                end
            end
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL lw_result: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_we !== e.we || out_pc !== e.pc) begin
                bad++;
                $display("FAIL lw_result: got v=%b res=%h we=%h pc=%h want v=1 res=%h we=%h pc=%h",
                         ms_to_ws_valid, out_res, out_we, out_pc, e.res, e.we, e.pc);
            end
        end
        total++;
        if (forward_ms_bus !== {1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL lw_forward: got %h want 1deadbeef", forward_ms_bus);
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL lw_leave: got valid=%b allowin=%b want 0 1", ms_to_ws_valid, ms_allowin);
        end
    endtask

    task automatic test_loads();
        logic [6:0]  ld  [6];
        logic [31:0] adr [6];
        logic [31:0] rd  [6];
        logic [31:0] res [6];
        logic [3:0]  we  [6];
        exp_t e;
        logic partial;
        ld[0] = LB;  adr[0] = 32'h80002003; rd[0] = 32'h80FF1234; res[0] = 32'hFFFFFF80; we[0] = 4'hF;
        ld[1] = LBU; adr[1] = 32'h80002003; rd[1] = 32'h80FF1234; res[1] = 32'h00000080; we[1] = 4'hF;
        ld[2] = LHU; adr[2] = 32'h80002002; rd[2] = 32'h80FF1234; res[2] = 32'h000080FF; we[2] = 4'hF;
        ld[3] = LWR; adr[3] = 32'h80002001; rd[3] = 32'hAABBCCDD; res[3] = 32'h00AABBCC; we[3] = 4'b0111;
        ld[4] = LWL; adr[4] = 32'h80002001; rd[4] = 32'hAABBCCDD; res[4] = 32'hCCDD0000; we[4] = 4'b1100;
        ld[5] = LH;  adr[5] = 32'h80002000; rd[5] = 32'h1234F00D; res[5] = 32'hFFFFF00D; we[5] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            es_to_ms_valid    = 1'b1;
            es_mem_req_ok     = 1'b1;
            es_to_ms_bus      = mk_in(ld[i], 1'b1, 5'd7, adr[i], 32'hBFC00200 + 32'(i * 4),
                                      1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
            sb.push_back('{res[i], we[i], 32'hBFC00200 + 32'(i * 4)});
            @(negedge clk);
            es_to_ms_valid    = 1'b0;
            es_mem_req_ok     = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd[i];
            #1;
            partial = (ld[i] == LWL) || (ld[i] == LWR);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL load_%0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_we !== e.we || out_pc !== e.pc) begin
                    bad++;
                    $display("FAIL load_%0d: got v=%b res=%h we=%h pc=%h want v=1 res=%h we=%h pc=%h",
                             i, ms_to_ws_valid, out_res, out_we, out_pc, e.res, e.we, e.pc);
                end
            end
            total++;
            if (forward_ms_bus[32] !== !partial) begin
                bad++;
                $display("FAIL load_fwd_%0d: got %b want %b", i, forward_ms_bus[32], !partial);
            end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_buffer();
        exp_t e;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd3, 32'h80003000, 32'hBFC00300, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        sb.push_back('{32'h11112222, 4'hF, 32'hBFC00300});
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        es_mem_req_ok     = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11112222;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h55555555 + 32'(c);
            #1;
            total++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1) begin
                bad++;
                $display("FAIL buffer_hold_%0d: got allowin=%b valid=%b want 0 1",
                         c, ms_allowin, ms_to_ws_valid);
            end
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL buffer_result: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_we !== e.we || out_pc !== e.pc) begin
                bad++;
                $display("FAIL buffer_result: got v=%b res=%h we=%h pc=%h want v=1 res=%h we=%h pc=%h",
                         ms_to_ws_valid, out_res, out_we, out_pc, e.res, e.we, e.pc);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL buffer_leave: got valid=%b want 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        // One orphan: flush a waiting lw, then a new lw must skip the stale response.
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd5, 32'h80004000, 32'hBFC00500, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        es_mem_req_ok  = 1'b0;
        flush          = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || stall_ms_bus[9:5] !== 5'd0) begin
            bad++;
            $display("FAIL flush_kill: got valid=%b allowin=%b mask=%h want 0 1 0",
                     ms_to_ws_valid, ms_allowin, stall_ms_bus[9:5]);
        end
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd6, 32'h80004004, 32'hBFC00504, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        sb.push_back('{32'h600DF00D, 4'hF, 32'hBFC00504});
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        es_mem_req_ok     = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAADBAAD;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop: got valid=%b res=%h want valid=0", ms_to_ws_valid, out_res);
        end
        @(negedge clk);
        data_sram_rdata = 32'h600DF00D;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL flush_next: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_pc !== e.pc) begin
                bad++;
                $display("FAIL flush_next: got v=%b res=%h pc=%h want v=1 res=%h pc=%h",
                         ms_to_ws_valid, out_res, out_pc, e.res, e.pc);
            end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        // Two orphans: the waiting lw plus a request accepted in the flush cycle.
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd8, 32'h80004008, 32'hBFC00508, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        es_to_ms_bus = mk_in(LW, 1'b1, 5'd9, 32'h8000400C, 32'hBFC0050C, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        flush        = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        es_to_ms_bus = mk_in(LW, 1'b1, 5'd10, 32'h80004010, 32'hBFC00510, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        sb.push_back('{32'hCAFE0001, 4'hF, 32'hBFC00510});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            es_to_ms_valid    = 1'b0;
            es_mem_req_ok     = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hBAAD0000 + 32'(k);
            #1;
            total++;
            if (ms_to_ws_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush2_drop_%0d: got valid=%b res=%h want valid=0",
                         k, ms_to_ws_valid, out_res);
            end
        end
        @(negedge clk);
        data_sram_rdata = 32'hCAFE0001;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL flush2_next: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_pc !== e.pc) begin
                bad++;
                $display("FAIL flush2_next: got v=%b res=%h pc=%h want v=1 res=%h pc=%h",
                         ms_to_ws_valid, out_res, out_pc, e.res, e.pc);
            end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_mem_req_ok  = 1'b1;
        es_to_ms_bus   = mk_in(LW, 1'b1, 5'd11, 32'h80005000, 32'hBFC00600, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        sb.push_back('{32'hA0A0A0A0, 4'hF, 32'hBFC00600});
        sb.push_back('{32'hB1B1B1B1, 4'hF, 32'hBFC00604});
        @(negedge clk);
        es_to_ms_bus      = mk_in(LW, 1'b1, 5'd12, 32'h80005004, 32'hBFC00604, 1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hA0A0A0A0;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL b2b_first: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || out_res !== e.res || out_pc !== e.pc) begin
                bad++;
                $display("FAIL b2b_first: got v=%b allowin=%b res=%h pc=%h want v=1 allowin=1 res=%h pc=%h",
                         ms_to_ws_valid, ms_allowin, out_res, out_pc, e.res, e.pc);
            end
        end
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        es_mem_req_ok     = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        total++;
        if (ms_to_ws_valid !== 1'b0 || stall_ms_bus !== {5'h1f, 5'd12}) begin
            bad++;
            $display("FAIL b2b_wait: got valid=%b stall=%h want 0 3ec", ms_to_ws_valid, stall_ms_bus);
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hB1B1B1B1;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL b2b_second: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (ms_to_ws_valid !== 1'b1 || out_res !== e.res || out_pc !== e.pc) begin
                bad++;
                $display("FAIL b2b_second: got v=%b res=%h pc=%h want v=1 res=%h pc=%h",
                         ms_to_ws_valid, out_res, out_pc, e.res, e.pc);
            end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_exception();
        logic [147:0] bin  [2];
        logic [136:0] bout [2];
        bin[0]  = mk_in(7'd0, 1'b0, 5'd0, 32'h80000003, 32'hBFC00400, 1'b1, 15'h0010, 1'b1, 1'b1, 32'h12345678);
        bout[0] = mk_out(4'h0, 5'd0, 32'h80000003, 32'hBFC00400, 1'b1, 15'h0010, 1'b1, 32'h12345678);
        bin[1]  = mk_in(LW, 1'b1, 5'd9, 32'h80000002, 32'hBFC00404, 1'b1, 15'h0008, 1'b0, 1'b0, 32'd0);
        bout[1] = mk_out(4'h0, 5'd9, 32'h13572468, 32'hBFC00404, 1'b1, 15'h0008, 1'b0, 32'd0);
        data_sram_rdata = 32'h13572468;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b1;
            es_mem_req_ok  = 1'b0;
            es_to_ms_bus   = bin[i];
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            #1;
            total++;
            if (ms_to_ws_valid !== 1'b1 || ms_exc_eret !== 1'b1 || ms_to_ws_bus !== bout[i]) begin
                bad++;
                $display("FAIL exc_%0d: got v=%b exc=%b bus=%h want v=1 exc=1 bus=%h",
                         i, ms_to_ws_valid, ms_exc_eret, ms_to_ws_bus, bout[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        flush             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_mem_req_ok     = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        test_reset();
        test_lw();
        test_loads();
        test_buffer();
        test_flush();
        test_back_to_back();
        test_exception();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
